lectura_rtc_seq: RTL and testbench
==================================

# lectura_rtc_seq

Read-sweep sequencer for the RTC register bus: on a start pulse it walks the time/date register addresses 8'h21..8'h28 in order, issues one read request per address to the bus timing controller, and streams each returned byte out with its index. Together with the write-address decoder it is the read-side counterpart of the RTC access path, sitting between the top-level control FSM and the multiplexed-bus timing generator.

## Interface
- FIRST_ADDR, 8'h21, address of first register read
- NUM_REGS, 8, registers per sweep (1..15)
- ACK_TIMEOUT, 255, max cycles waiting for bus_ack (only with RD_TIMEOUT_EN)

- clk  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse, begin a sweep (ignored while busy)
- rd_req  out  1  read request to bus timing controller
- rd_addr  out  8  register address, stable while rd_req=1
- bus_ack  in  1  bus controller: read complete, bus_data valid this cycle
- bus_data  in  8  byte returned by RTC
- data_out  out  8  captured byte
- data_idx  out  4  index 0..NUM_REGS-1 of data_out
- data_valid  out  1  one-cycle pulse, data_out/data_idx valid
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse, sweep completed normally
- err  out  1  one-cycle pulse, sweep aborted on timeout (constant 0 without macro)

## Operation
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: rd_req=0, rd_addr=8'h00, busy=0. start=1 -> idx=0, go ISSUE.
- ISSUE: rd_req=1, rd_addr=FIRST_ADDR+idx, busy=1. bus_ack=1 -> latch bus_data into data_out, idx into data_idx, go CAPTURE.
- CAPTURE: rd_req=0 (one turnaround cycle), data_valid=1. idx==NUM_REGS-1 -> DONE; else idx+1, go ISSUE.
- DONE: done=1, busy=0, go IDLE.
- Address arithmetic 8-bit, FIRST_ADDR+NUM_REGS-1 must not exceed 8'hFF; no wrap.
- bus_ack outside ISSUE ignored; start outside IDLE ignored.
- All outputs registered. Reset values: rd_req 0, rd_addr 8'h00, data_out 8'h00, data_idx 0, data_valid 0, busy 0, done 0, err 0; state IDLE.
- reset=0 mid-sweep: next edge forces reset values, rd_req drops, no done/err, sweep lost.

## Timing
- start sampled at edge k -> rd_req=1, busy=1 from cycle after k.
- bus_ack sampled with rd_req=1 at edge m -> cycle after m: rd_req=0, data_valid=1, data_out=bus_data(m).
- Next rd_req rises one cycle after data_valid; minimum 2 cycles per register, 2*NUM_REGS+1 cycles start-to-done with immediate acks.
- done pulses the cycle after the last data_valid; busy low in that same cycle.
- rd_addr changes only on ISSUE entry; never changes while rd_req=1.

## Configuration
- RD_TIMEOUT_EN defined: 8-bit counter clears on ISSUE entry, increments each ISSUE cycle without bus_ack; reaching ACK_TIMEOUT -> next cycle rd_req=0, err=1, busy=0, state IDLE, no done. bus_ack on the expiry cycle wins (normal capture).
- Undefined: no counter, ISSUE waits indefinitely, err tied 0.

## Structure
- Package rtc_rd_pkg: state enum (IDLE/ISSUE/CAPTURE/DONE), RTC_FIRST_RD_ADDR=8'h21, RTC_NUM_REGS=8, index width constant.
- One sub-module natural: rd_timeout_cnt (clear/enable/expire), instantiated only under RD_TIMEOUT_EN.

## Test plan
- Reset then start, bus_ack one cycle after each rd_req, bus_data=8'h10+idx -> rd_addr 8'h21..8'h28 in order, 8 data_valid pulses with data_out 8'h10..8'h17, idx 0..7, done after 17 cycles, err=0.
- bus_ack delayed 5 cycles on idx 3 -> rd_addr=8'h24 held stable all 6 cycles, data_valid only after ack.
- start pulsed during sweep and bus_ack pulsed in IDLE/CAPTURE -> no restart, no extra data_valid.
- reset=0 asserted while idx=4 in ISSUE -> next cycle all outputs at reset values, no done; new start sweeps from 8'h21.
- RD_TIMEOUT_EN, ACK_TIMEOUT=10, no bus_ack on idx 2 -> err pulse after 10 ISSUE cycles, rd_req low, busy low, no done; ack arriving exactly on cycle 10 -> normal capture, no err.
- Parameter override FIRST_ADDR=8'h31, NUM_REGS=3 -> addresses 8'h31..8'h33, done after 7 cycles.

Source files
------------

// File: rtl/rtc_rd_pkg.sv
// Shared constants and FSM state encoding for the RTC read-sweep sequencer.
package rtc_rd_pkg;

  localparam int unsigned RTC_IDX_W       = 4;
  localparam logic [7:0]  RTC_FIRST_RD_ADDR = 8'h21;
  localparam int unsigned RTC_NUM_REGS    = 8;
  localparam int unsigned RTC_ACK_TIMEOUT = 255;

  typedef logic [1:0] rd_state_t;

  localparam rd_state_t StIdle    = 2'd0;
  localparam rd_state_t StIssue   = 2'd1;
  localparam rd_state_t StCapture = 2'd2;
  localparam rd_state_t StDone    = 2'd3;

endpackage

// File: rtl/rd_timeout_cnt.sv
// Bus-ack watchdog: counts ISSUE cycles without an ack and flags the final allowed cycle.
module rd_timeout_cnt #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'h00;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High during the Limit-th waiting cycle; an ack in that same cycle still wins upstream.
  assign expire_o = (cnt_q == 8'(Limit - 1));

endmodule

// File: rtl/lectura_rtc_seq.sv
// RTC read-sweep sequencer: reads NUM_REGS registers from FIRST_ADDR and streams the bytes out.
// Optional ack watchdog enabled by defining RD_TIMEOUT_EN.
module lectura_rtc_seq
  import rtc_rd_pkg::*;
#(
  parameter logic [7:0]  FIRST_ADDR  = RTC_FIRST_RD_ADDR,
  parameter int unsigned NUM_REGS    = RTC_NUM_REGS,
  parameter int unsigned ACK_TIMEOUT = RTC_ACK_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 rd_req,
  output logic [7:0]           rd_addr,
  input  logic                 bus_ack,
  input  logic [7:0]           bus_data,
  output logic [7:0]           data_out,
  output logic [RTC_IDX_W-1:0] data_idx,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [RTC_IDX_W-1:0] LastIdx = RTC_IDX_W'(NUM_REGS - 1);

  rd_state_t            state_q, state_d;
  logic [RTC_IDX_W-1:0] idx_q, idx_d;
  logic                 rd_req_q, rd_req_d;
  logic [7:0]           rd_addr_q, rd_addr_d;
  logic [7:0]           data_out_q, data_out_d;
  logic [RTC_IDX_W-1:0] data_idx_q, data_idx_d;
  logic                 data_valid_q, data_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cnt_clr, cnt_en, ack_expire;

`ifdef RD_TIMEOUT_EN
  rd_timeout_cnt #(
    .Limit(ACK_TIMEOUT)
  ) u_rd_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .expire_o(ack_expire)
  );
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr, cnt_en, 8'(ACK_TIMEOUT)};
  assign ack_expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rd_req_d     = rd_req_q;
    rd_addr_d    = rd_addr_q;
    data_out_d   = data_out_q;
    data_idx_d   = data_idx_q;
    data_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StIssue;
          idx_d     = '0;
          rd_req_d  = 1'b1;
          rd_addr_d = FIRST_ADDR;
          busy_d    = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      StIssue: begin
        if (bus_ack) begin
          state_d      = StCapture;
          rd_req_d     = 1'b0;
          data_out_d   = bus_data;
          data_idx_d   = idx_q;
          data_valid_d = 1'b1;
        end else if (ack_expire) begin
          state_d   = StIdle;
          rd_req_d  = 1'b0;
          rd_addr_d = 8'h00;
          busy_d    = 1'b0;
          err_d     = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StCapture: begin
        if (idx_q == LastIdx) begin
          state_d   = StDone;
          rd_addr_d = 8'h00;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          state_d   = StIssue;
          idx_d     = idx_q + 1'b1;
          rd_req_d  = 1'b1;
          // Sum is bounded by FIRST_ADDR+NUM_REGS-1, which must not pass 8'hFF.
          rd_addr_d = FIRST_ADDR + {{(8 - RTC_IDX_W){1'b0}}, idx_q} + 8'h01;
          cnt_clr   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      rd_req_q     <= 1'b0;
      rd_addr_q    <= 8'h00;
      data_out_q   <= 8'h00;
      data_idx_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rd_req_q     <= rd_req_d;
      rd_addr_q    <= rd_addr_d;
      data_out_q   <= data_out_d;
      data_idx_q   <= data_idx_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_addr    = rd_addr_q;
  assign data_out   = data_out_q;
  assign data_idx   = data_idx_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lectura_rtc_seq.sv
// Directed bench for lectura_rtc_seq: default sweep plus a 3-register override instance.
module tb_lectura_rtc_seq;

  logic       clk = 1'b0;
  logic       reset, start, start2, bus_ack;
  logic [7:0] bus_data;

  logic       rd_req, data_valid, busy, done, err;
  logic [7:0] rd_addr, data_out;
  logic [3:0] data_idx;
  logic       rd_req2, data_valid2, busy2, done2, err2;
  logic [7:0] rd_addr2, data_out2;
  logic [3:0] data_idx2;

  logic       sel;
  logic       s_rd_req, s_data_valid, s_busy, s_done, s_err;
  logic [7:0] s_rd_addr, s_data_out;
  logic [3:0] s_data_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lectura_rtc_seq #(
    .ACK_TIMEOUT(10)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .rd_req(rd_req), .rd_addr(rd_addr),
    .bus_ack(bus_ack), .bus_data(bus_data), .data_out(data_out), .data_idx(data_idx),
    .data_valid(data_valid), .busy(busy), .done(done), .err(err)
  );

  lectura_rtc_seq #(
    .FIRST_ADDR(8'h31),
    .NUM_REGS  (3)
  ) u_dut_small (
    .clk(clk), .reset(reset), .start(start2), .rd_req(rd_req2), .rd_addr(rd_addr2),
    .bus_ack(bus_ack), .bus_data(bus_data), .data_out(data_out2), .data_idx(data_idx2),
    .data_valid(data_valid2), .busy(busy2), .done(done2), .err(err2)
  );

  always_comb begin
    s_rd_req     = sel ? rd_req2     : rd_req;
    s_rd_addr    = sel ? rd_addr2    : rd_addr;
    s_data_out   = sel ? data_out2   : data_out;
    s_data_idx   = sel ? data_idx2   : data_idx;
    s_data_valid = sel ? data_valid2 : data_valid;
    s_busy       = sel ? busy2       : busy;
    s_done       = sel ? done2       : done;
    s_err        = sel ? err2        : err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rd_req"}, s_rd_req, 0);
    check_eq({tag, "_rd_addr"}, s_rd_addr, 8'h00);
    check_eq({tag, "_data_out"}, s_data_out, 8'h00);
    check_eq({tag, "_data_idx"}, s_data_idx, 0);
    check_eq({tag, "_data_valid"}, s_data_valid, 0);
    check_eq({tag, "_busy"}, s_busy, 0);
    check_eq({tag, "_done"}, s_done, 0);
    check_eq({tag, "_err"}, s_err, 0);
  endtask

  task automatic drive_start(input logic v);
    if (sel) start2 = v;
    else     start  = v;
  endtask

  task automatic idle_ack_pulse();
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check_eq("idle_ack_dv", s_data_valid, 0);
    check_eq("idle_ack_req", s_rd_req, 0);
    check_eq("idle_ack_busy", s_busy, 0);
  endtask

  // dly extra no-ack cycles on dly_idx; noise pokes start/bus_ack where they must be ignored;
  // abort_idx applies reset in that ISSUE cycle; tmo_idx withholds the ack for 10 cycles.
  task automatic sweep(input logic sel_i, input int n, input logic [7:0] first, input int dly_idx,
                       input int dly, input logic noise, input int abort_idx, input int tmo_idx);
    int  cyc;
    int  w;
    int  extra;
    logic quit;
    sel = sel_i;
    @(negedge clk);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    cyc   = 1;
    quit  = 1'b0;
    extra = (dly_idx >= 0 && dly_idx < n) ? dly : 0;
    for (int i = 0; i < n && !quit; i++) begin
      check_eq("issue_req", s_rd_req, 1);
      check_eq("issue_addr", s_rd_addr, first + i);
      check_eq("issue_busy", s_busy, 1);
      if (i == abort_idx) begin
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_reset_vals("abort");
        @(negedge clk);
        check_eq("abort_no_done", s_done, 0);
        check_eq("abort_no_req", s_rd_req, 0);
        quit = 1'b1;
      end else if (i == tmo_idx) begin
        for (int j = 1; j < 10; j++) begin
          @(negedge clk);
          check_eq("tmo_wait_req", s_rd_req, 1);
        end
        @(negedge clk);
        check_eq("tmo_err", s_err, 1);
        check_eq("tmo_req", s_rd_req, 0);
        check_eq("tmo_busy", s_busy, 0);
        check_eq("tmo_no_done", s_done, 0);
        @(negedge clk);
        check_eq("tmo_err_pulse", s_err, 0);
        check_eq("tmo_idle_req", s_rd_req, 0);
        quit = 1'b1;
      end else begin
        w = (i == dly_idx) ? dly : 0;
        for (int j = 0; j < w; j++) begin
          if (noise) drive_start(1'b1);
          @(negedge clk);
          drive_start(1'b0);
          cyc++;
          check_eq("wait_req", s_rd_req, 1);
          check_eq("addr_stable", s_rd_addr, first + i);
          check_eq("wait_no_dv", s_data_valid, 0);
        end
        bus_ack  = 1'b1;
        bus_data = 8'h10 + 8'(i);
        @(negedge clk);
        bus_ack  = 1'b0;
        bus_data = 8'hEE;
        cyc++;
        check_eq("cap_req", s_rd_req, 0);
        check_eq("cap_dv", s_data_valid, 1);
        check_eq("cap_data", s_data_out, 8'h10 + i);
        check_eq("cap_idx", s_data_idx, i);
        check_eq("cap_err", s_err, 0);
        if (noise) begin
          drive_start(1'b1);
          bus_ack = 1'b1;
        end
        @(negedge clk);
        drive_start(1'b0);
        bus_ack = 1'b0;
        cyc++;
        check_eq("dv_pulse", s_data_valid, 0);
      end
    end
    if (!quit) begin
      check_eq("done", s_done, 1);
      check_eq("done_busy", s_busy, 0);
      check_eq("done_err", s_err, 0);
      check_eq("done_req", s_rd_req, 0);
      check_eq("done_cycles", cyc, 2 * n + 1 + extra);
      @(negedge clk);
      check_eq("done_pulse", s_done, 0);
      check_eq("idle_req", s_rd_req, 0);
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    start2   = 1'b0;
    bus_ack  = 1'b0;
    bus_data = 8'h00;
    sel      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    idle_ack_pulse();
    sweep(1'b0, 8, 8'h21, -1, 0, 1'b0, -1, -1);
    sweep(1'b0, 8, 8'h21, 3, 5, 1'b1, -1, -1);
    idle_ack_pulse();
    sweep(1'b0, 8, 8'h21, -1, 0, 1'b0, 4, -1);
    sweep(1'b0, 8, 8'h21, -1, 0, 1'b0, -1, -1);
`ifdef RD_TIMEOUT_EN
    sweep(1'b0, 8, 8'h21, -1, 0, 1'b0, -1, 2);
    sweep(1'b0, 8, 8'h21, 2, 9, 1'b0, -1, -1);
`endif
    sweep(1'b1, 3, 8'h31, -1, 0, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
